// File: rtl/bkm_digit_select_csd.sv
// BKM E-mode digit selection: forms a K-digit signed estimate from the leading CSD residual digits and issues d_x/d_y.
// Optional feature macro BKM_DIGIT_SEL_ERR_EN adds a sticky sel_err flag for forbidden CSD codes.
module bkm_digit_select_csd #(
    parameter int W   = 64,
    parameter int N   = 64,
    parameter int K   = 4,
    parameter int T_X = 2,
    parameter int T_Y = 2
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   start,
    input  logic                   res_valid,
    input  logic [2*W-1:0]         ex_in,
    input  logic [2*W-1:0]         ey_in,
    input  logic                   d_ready,
    output logic                   d_valid,
    output logic [1:0]             d_x,
    output logic [1:0]             d_y,
    output logic [$clog2(N)-1:0]   iter,
    output logic                   busy,
    output logic                   done
`ifdef BKM_DIGIT_SEL_ERR_EN
    ,
    output logic                   sel_err
`endif
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0]    LAST = IW'(N - 1);
    localparam logic signed [K:0] TX  = (K+1)'(T_X);
    localparam logic signed [K:0] TY  = (K+1)'(T_Y);

    typedef enum logic [2:0] {IDLE, WAIT_RES, EST, SEL, DONE} state_t;

    state_t              state, state_nxt;
    logic [2*K-1:0]      win_x, win_y;
    logic signed [K:0]   vx, vy;

    // Window digit j carries weight 2^j; forbidden code 10 contributes nothing.
    function automatic logic signed [K:0] csd_value(input logic [2*K-1:0] w);
        logic signed [K:0] acc;
        logic signed [K:0] p;
        acc = '0;
        for (int unsigned j = 0; j < K; j++) begin
            p    = '0;
            p[j] = 1'b1;
            if (w[2*j +: 2] == 2'b01)
                acc = acc + p;
            else if (w[2*j +: 2] == 2'b11)
                acc = acc - p;
        end
        return acc;
    endfunction

    function automatic logic [1:0] select_digit(input logic signed [K:0] v,
                                                input logic signed [K:0] t);
        if (v >= t)
            return 2'b01;
        else if (v <= -t)
            return 2'b11;
        else
            return 2'b00;
    endfunction

    always_ff @(posedge clk or posedge arst) begin
        if (arst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == DONE);
        case (state)
            IDLE:     if (start) state_nxt = WAIT_RES;
            WAIT_RES: if (res_valid) state_nxt = EST;
            EST:      state_nxt = SEL;
            SEL:      if (d_valid && d_ready) state_nxt = (iter == LAST) ? DONE : WAIT_RES;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            win_x   <= '0;
            win_y   <= '0;
            vx      <= '0;
            vy      <= '0;
            d_valid <= 1'b0;
            d_x     <= '0;
            d_y     <= '0;
            iter    <= '0;
        end else begin
            case (state)
                IDLE: if (start) iter <= '0;
                WAIT_RES: if (res_valid) begin
                    win_x <= ex_in[2*W-1 -: 2*K];
                    win_y <= ey_in[2*W-1 -: 2*K];
                end
                EST: begin
                    vx <= csd_value(win_x);
                    vy <= csd_value(win_y);
                end
                // First SEL cycle registers the digit; it then holds until accepted.
                SEL: if (!d_valid) begin
                    d_x     <= select_digit(vx, TX);
                    d_y     <= select_digit(vy, TY);
                    d_valid <= 1'b1;
                end else if (d_ready) begin
                    d_valid <= 1'b0;
                    if (iter != LAST) iter <= iter + IW'(1);
                end
                DONE: iter <= '0;
                default: ;
            endcase
        end
    end

`ifdef BKM_DIGIT_SEL_ERR_EN
    function automatic logic has_forbidden(input logic [2*K-1:0] w);
        logic f;
        f = 1'b0;
        for (int unsigned j = 0; j < K; j++)
            if (w[2*j +: 2] == 2'b10) f = 1'b1;
        return f;
    endfunction

    always_ff @(posedge clk or posedge arst) begin
        if (arst)
            sel_err <= 1'b0;
        else if (state == IDLE && start)
            sel_err <= 1'b0;
        else if (state == WAIT_RES && res_valid &&
                 (has_forbidden(ex_in[2*W-1 -: 2*K]) || has_forbidden(ey_in[2*W-1 -: 2*K])))
            sel_err <= 1'b1;
    end
`endif

    generate
        if (K < W) begin : g_low_digits
            logic unused_low;
            assign unused_low = ^{ex_in[2*W-2*K-1:0], ey_in[2*W-2*K-1:0]};
        end
    endgenerate

endmodule
